// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared FSM state type, RV32I opcodes and instruction field slices for alu_seq
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_e;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam int OPC_MSB = 6;
    localparam int OPC_LSB = 0;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 7;
    localparam int F3_MSB  = 14;
    localparam int F3_LSB  = 12;
    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 24;
    localparam int RS2_LSB = 20;
    localparam int F7_MSB  = 31;
    localparam int F7_LSB  = 25;
    localparam int IMM_MSB = 31;
    localparam int IMM_LSB = 20;

    // alu_opcode is {instr[ALU_OP_BIT], instr[ALU_ALT_BIT], funct3}
    localparam int ALU_OP_BIT  = 5;
    localparam int ALU_ALT_BIT = 30;

    function automatic logic is_supported(input logic [6:0] opc, input logic [6:0] f7);
        return (opc == OPC_OPIMM) || ((opc == OPC_OP) && ((f7 == F7_BASE) || (f7 == F7_ALT)));
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - issue, ALU and writeback signals between alu_seq and its environment
interface alu_seq_if #(
    parameter int XLEN = 32
) ();
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] alu_rs1;
    logic [XLEN-1:0] alu_rs2;
    logic [4:0]      alu_opcode;
    logic [XLEN-1:0] alu_res;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            illegal;

    modport master (
        output instr_valid, instr, alu_res,
        input  instr_ready, alu_rs1, alu_rs2, alu_opcode, wb_valid, wb_rd, wb_data, illegal
    );

    modport slave (
        input  instr_valid, instr, alu_res,
        output instr_ready, alu_rs1, alu_rs2, alu_opcode, wb_valid, wb_rd, wb_data, illegal
    );
endinterface

// File: rtl/alu_seq_regfile.sv
// rtl/alu_seq_regfile.sv - 32-entry register file, two combinational reads, one synchronous write, x0 fixed at 0
module alu_seq_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      i_rs1_addr,
    input  logic [4:0]      i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    input  logic            i_we,
    input  logic [4:0]      i_rd_addr,
    input  logic [XLEN-1:0] i_rd_data
);
    logic [XLEN-1:0] r_regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_rd_addr != 5'd0)) begin
            r_regs[i_rd_addr] <= i_rd_data;
        end
    end

    assign o_rs1_data = (i_rs1_addr == 5'd0) ? '0 : r_regs[i_rs1_addr];
    assign o_rs2_data = (i_rs2_addr == 5'd0) ? '0 : r_regs[i_rs2_addr];
endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - four-state sequencer issuing RV32I OP/OP-IMM instructions to an external ALU
// ALU_SEQ_ILLEGAL_TRAP_EN: unsupported instructions raise illegal and block issue until rst
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    state_e          r_state;
    state_e          w_next_state;
    logic [31:0]     r_instr;
    logic            r_legal;
    logic [XLEN-1:0] r_alu_rs1;
    logic [XLEN-1:0] r_alu_rs2;
    logic [4:0]      r_alu_opcode;
    logic            r_wb_valid;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;

    logic            w_accept;
    logic            w_supported;
    logic            w_trapped;
    logic            w_we;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_opb;

    assign w_supported = is_supported(bus.instr[OPC_MSB:OPC_LSB], bus.instr[F7_MSB:F7_LSB]);

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic r_trap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trap <= 1'b0;
        end else if (w_accept && !w_supported) begin
            r_trap <= 1'b1;
        end
    end

    assign w_trapped   = r_trap;
    assign bus.illegal = r_trap;
`else
    assign w_trapped   = 1'b0;
    assign bus.illegal = 1'b0;
`endif

    assign bus.instr_ready = (r_state == ST_IDLE) && !w_trapped;
    assign w_accept        = bus.instr_valid && bus.instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                    w_next_state = w_supported ? ST_DECODE : ST_IDLE;
`else
                    w_next_state = ST_DECODE;
`endif
                end
            end
            ST_DECODE: w_next_state = ST_EXEC;
            ST_EXEC:   w_next_state = ST_WB;
            ST_WB:     w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Shift-immediates pass the whole sign-extended field; the ALU only looks at b[4:0]
    assign w_imm = {{(XLEN-12){r_instr[IMM_MSB]}}, r_instr[IMM_MSB:IMM_LSB]};
    assign w_opb = (r_instr[OPC_MSB:OPC_LSB] == OPC_OPIMM) ? w_imm : w_rs2_data;
    assign w_we  = r_wb_valid && (r_wb_rd != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr      <= '0;
            r_legal      <= 1'b0;
            r_alu_rs1    <= '0;
            r_alu_rs2    <= '0;
            r_alu_opcode <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_instr <= bus.instr;
                        r_legal <= w_supported;
                    end
                end
                ST_DECODE: begin
                    r_alu_rs1    <= w_rs1_data;
                    r_alu_rs2    <= w_opb;
                    r_alu_opcode <= {r_instr[ALU_OP_BIT], r_instr[ALU_ALT_BIT], r_instr[F3_MSB:F3_LSB]};
                end
                ST_EXEC: begin
                    // An unsupported instruction walks the pipeline as a NOP and never retires
                    r_wb_valid <= r_legal;
                    if (r_legal) begin
                        r_wb_rd   <= r_instr[RD_MSB:RD_LSB];
                        r_wb_data <= bus.alu_res;
                    end
                end
                ST_WB: begin
                    r_wb_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    alu_seq_regfile #(.XLEN(XLEN)) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_rs1_addr (r_instr[RS1_MSB:RS1_LSB]),
        .i_rs2_addr (r_instr[RS2_MSB:RS2_LSB]),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .i_we       (w_we),
        .i_rd_addr  (r_wb_rd),
        .i_rd_data  (r_wb_data)
    );

    assign bus.alu_rs1    = r_alu_rs1;
    assign bus.alu_rs2    = r_alu_rs2;
    assign bus.alu_opcode = r_alu_opcode;
    assign bus.wb_valid   = r_wb_valid;
    assign bus.wb_rd      = r_wb_rd;
    assign bus.wb_data    = r_wb_data;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq against an instruction-level model
module tb_alu_seq;
    localparam int CLK_NS = 10;

    logic clk = 1'b0;
    logic rst;
    always #(CLK_NS/2) clk = ~clk;

    alu_seq_if #(.XLEN(32)) bus_if ();

    alu_seq #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mregs [32];
    time         last_acc;
    logic [31:0] cap_rs1, cap_rs2, cap_wb_data;
    logic [4:0]  cap_opc, cap_wb_rd;
    logic        cap_wb_valid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // External ALU: combinational from the operand/opcode outputs
    always_comb begin
        bus_if.alu_res = 32'h0;
        case (bus_if.alu_opcode[2:0])
            3'b000: bus_if.alu_res = (bus_if.alu_opcode[4] && bus_if.alu_opcode[3]) ?
                                     bus_if.alu_rs1 - bus_if.alu_rs2 : bus_if.alu_rs1 + bus_if.alu_rs2;
            3'b001: bus_if.alu_res = bus_if.alu_rs1 << bus_if.alu_rs2[4:0];
            3'b010: bus_if.alu_res = {31'b0, $signed(bus_if.alu_rs1) < $signed(bus_if.alu_rs2)};
            3'b011: bus_if.alu_res = {31'b0, bus_if.alu_rs1 < bus_if.alu_rs2};
            3'b100: bus_if.alu_res = bus_if.alu_rs1 ^ bus_if.alu_rs2;
            3'b101: bus_if.alu_res = bus_if.alu_opcode[3] ?
                                     32'($signed(bus_if.alu_rs1) >>> bus_if.alu_rs2[4:0]) :
                                     bus_if.alu_rs1 >> bus_if.alu_rs2[4:0];
            3'b110: bus_if.alu_res = bus_if.alu_rs1 | bus_if.alu_rs2;
            default: bus_if.alu_res = bus_if.alu_rs1 & bus_if.alu_rs2;
        endcase
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic model_legal(input logic [31:0] ins);
        if (ins[6:0] == 7'b0010011) return 1'b1;
        if (ins[6:0] == 7'b0110011) return (ins[31:25] == 7'h00) || (ins[31:25] == 7'h20);
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_opb(input logic [31:0] ins);
        if (ins[6:0] == 7'b0010011) return {{20{ins[31]}}, ins[31:20]};
        return mregs[ins[24:20]];
    endfunction

    // Architectural RV32I result of the instruction given the model register file
    function automatic logic [31:0] model_exec(input logic [31:0] ins);
        logic [31:0] a, b;
        logic        is_reg_op;
        a         = mregs[ins[19:15]];
        b         = model_opb(ins);
        is_reg_op = (ins[6:0] == 7'b0110011);
        case (ins[14:12])
            3'b000: return (is_reg_op && ins[31:25] == 7'h20) ? a - b : a + b;   // ADD/SUB/ADDI
            3'b001: return a << b[4:0];                                            // SLL/SLLI
            3'b010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;              // SLT/SLTI
            3'b011: return (a < b) ? 32'd1 : 32'd0;                                // SLTU/SLTIU
            3'b100: return a ^ b;
            3'b101: return ins[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];     // SRA/SRL
            3'b110: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr(input bit allow_bad);
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        int          kind;
        rd   = 5'($urandom);
        rs1  = 5'($urandom);
        rs2  = 5'($urandom);
        f3   = 3'($urandom);
        kind = $urandom_range(0, 9);
        if (allow_bad && kind == 9) begin
            if ($urandom_range(0, 1) == 0) return {20'($urandom), rd, 7'b0000011};
            return enc_r(7'b0000001, rs2, rs1, f3, rd);
        end
        if (kind < 5) begin
            return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                         rs2, rs1, f3, rd);
        end
        imm = 12'($urandom);
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        else if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return enc_i(imm, rs1, f3, rd);
    endfunction

    // Offers one instruction and follows it through DECODE/EXEC/WB to the next IDLE cycle
    task automatic issue(input logic [31:0] ins, input bit hold, input bit chk_gap, input string tag);
        logic        sup;
        logic [31:0] exp_a, exp_b, exp_res;
        logic [4:0]  rd;
        int          waited;
        time         t_acc;
        sup     = model_legal(ins);
        exp_a   = mregs[ins[19:15]];
        exp_b   = model_opb(ins);
        exp_res = model_exec(ins);
        rd      = ins[11:7];
        bus_if.instr       = ins;
        bus_if.instr_valid = 1'b1;
        waited = 0;
        while (bus_if.instr_ready !== 1'b1 && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        if (bus_if.instr_ready !== 1'b1) begin
            check_eq({tag, "_ready_timeout"}, 32'(bus_if.instr_ready), 32'd1);
            bus_if.instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        t_acc = $time;
        if (chk_gap) check_eq({tag, "_gap"}, 32'((t_acc - last_acc) / CLK_NS), 32'd4);
        last_acc = t_acc;

        @(negedge clk);
        if (!hold) bus_if.instr_valid = 1'b0;
        check_eq({tag, "_dec_ready"}, 32'(bus_if.instr_ready), 32'd0);
        check_eq({tag, "_dec_wbv"}, 32'(bus_if.wb_valid), 32'd0);

        @(negedge clk);
        check_eq({tag, "_exe_ready"}, 32'(bus_if.instr_ready), 32'd0);
        cap_rs1 = bus_if.alu_rs1;
        cap_rs2 = bus_if.alu_rs2;
        cap_opc = bus_if.alu_opcode;
        if (sup) begin
            check_eq({tag, "_rs1"}, bus_if.alu_rs1, exp_a);
            check_eq({tag, "_rs2"}, bus_if.alu_rs2, exp_b);
            check_eq({tag, "_opc"}, 32'(bus_if.alu_opcode), 32'({ins[5], ins[30], ins[14:12]}));
        end

        @(negedge clk);
        check_eq({tag, "_wb_ready"}, 32'(bus_if.instr_ready), 32'd0);
        check_eq({tag, "_wbv"}, 32'(bus_if.wb_valid), 32'(sup));
        check_eq({tag, "_illegal"}, 32'(bus_if.illegal), 32'd0);
        cap_wb_valid = bus_if.wb_valid;
        cap_wb_rd    = bus_if.wb_rd;
        cap_wb_data  = bus_if.wb_data;
        if (sup) begin
            check_eq({tag, "_wbrd"}, 32'(bus_if.wb_rd), 32'(rd));
            check_eq({tag, "_wbdata"}, bus_if.wb_data, exp_res);
        end

        @(negedge clk);
        check_eq({tag, "_idle_wbv"}, 32'(bus_if.wb_valid), 32'd0);
        check_eq({tag, "_idle_ready"}, 32'(bus_if.instr_ready), 32'd1);
        if (sup && rd != 5'd0) mregs[rd] = exp_res;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    endtask

    task automatic read_all_regs(input string tag);
        for (int i = 1; i < 32; i++) begin
            issue(enc_r(7'h00, 5'((i == 31) ? 1 : i + 1), 5'(i), 3'b110, 5'(i)), 1'b0, 1'b0, tag);
        end
    endtask

    initial begin
        #(CLK_NS * 40000);
        $display("FAIL watchdog: got no finish expected finish within budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit allow_bad;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        allow_bad = 1'b0;
`else
        allow_bad = 1'b1;
`endif
        rst                = 1'b1;
        bus_if.instr_valid = 1'b0;
        bus_if.instr       = 32'h0;
        last_acc           = 0;
        clear_model();

        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(bus_if.instr_ready), 32'd1);
        check_eq("rst_wbv", 32'(bus_if.wb_valid), 32'd0);
        check_eq("rst_wbrd", 32'(bus_if.wb_rd), 32'd0);
        check_eq("rst_wbdata", bus_if.wb_data, 32'd0);
        check_eq("rst_rs1", bus_if.alu_rs1, 32'd0);
        check_eq("rst_rs2", bus_if.alu_rs2, 32'd0);
        check_eq("rst_opc", 32'(bus_if.alu_opcode), 32'd0);
        check_eq("rst_illegal", 32'(bus_if.illegal), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", 32'(bus_if.instr_ready), 32'd1);
        check_eq("post_rst_wbv", 32'(bus_if.wb_valid), 32'd0);
        check_eq("post_rst_opc", 32'(bus_if.alu_opcode), 32'd0);

        issue(enc_i(12'd5, 5'd0, 3'b000, 5'd1), 1'b0, 1'b0, "addi_x1");
        check_eq("spec_addi_rd", 32'(cap_wb_rd), 32'd1);
        check_eq("spec_addi_data", cap_wb_data, 32'h00000005);
        issue(enc_i(12'd7, 5'd0, 3'b000, 5'd2), 1'b0, 1'b0, "addi_x2");
        issue(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3), 1'b0, 1'b0, "sub_x3");
        check_eq("spec_sub_opc", 32'(cap_opc), 32'b11000);
        check_eq("spec_sub_data", cap_wb_data, 32'hFFFFFFFE);
        issue(enc_r(7'h00, 5'd1, 5'd3, 3'b010, 5'd4), 1'b0, 1'b0, "slt_x4");
        check_eq("spec_slt_data", cap_wb_data, 32'd1);
        issue(enc_i(12'hFFF, 5'd1, 3'b100, 5'd5), 1'b0, 1'b0, "xori_x5");
        check_eq("spec_xori_rs2", cap_rs2, 32'hFFFFFFFF);
        check_eq("spec_xori_data", cap_wb_data, 32'hFFFFFFFA);
        issue(enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd0), 1'b0, 1'b0, "add_x0");
        check_eq("spec_x0_wbv", 32'(cap_wb_valid), 32'd1);
        check_eq("spec_x0_rd", 32'(cap_wb_rd), 32'd0);
        check_eq("spec_x0_data", cap_wb_data, 32'd10);
        issue(enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd6), 1'b0, 1'b0, "read_x0");
        check_eq("spec_x0_reads0", cap_rs1, 32'd0);

        issue(enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd7), 1'b1, 1'b0, "b2b_a");
        issue(enc_r(7'h00, 5'd5, 5'd3, 3'b111, 5'd8), 1'b1, 1'b1, "b2b_b");
        issue(enc_r(7'h00, 5'd8, 5'd7, 3'b000, 5'd9), 1'b0, 1'b1, "b2b_c");

        for (int k = 0; k < 250; k++) begin
            issue(rand_instr(allow_bad), 1'b0, 1'b0, "rnd");
        end

        // Reset while the instruction sits in EXEC
        bus_if.instr       = enc_i(12'd9, 5'd0, 3'b000, 5'd7);
        bus_if.instr_valid = 1'b1;
        check_eq("rstx_pre_ready", 32'(bus_if.instr_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus_if.instr_valid = 1'b0;
        @(negedge clk);
        check_eq("rstx_exec_rs2", bus_if.alu_rs2, 32'd9);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstx_wbv", 32'(bus_if.wb_valid), 32'd0);
        check_eq("rstx_ready", 32'(bus_if.instr_ready), 32'd1);
        check_eq("rstx_rs2", bus_if.alu_rs2, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rstx_after_wbv", 32'(bus_if.wb_valid), 32'd0);
        check_eq("rstx_after_ready", 32'(bus_if.instr_ready), 32'd1);
        clear_model();
        read_all_regs("rdback");

        issue(enc_i(12'h7FF, 5'd0, 3'b000, 5'd10), 1'b0, 1'b0, "pre_bad");
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        bus_if.instr       = 32'h00002083;
        bus_if.instr_valid = 1'b1;
        check_eq("trap_pre_ready", 32'(bus_if.instr_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus_if.instr_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check_eq("trap_illegal", 32'(bus_if.illegal), 32'd1);
            check_eq("trap_ready", 32'(bus_if.instr_ready), 32'd0);
            check_eq("trap_wbv", 32'(bus_if.wb_valid), 32'd0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check_eq("trap_rst_illegal", 32'(bus_if.illegal), 32'd0);
        check_eq("trap_rst_ready", 32'(bus_if.instr_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        clear_model();
        issue(enc_i(12'd3, 5'd0, 3'b000, 5'd11), 1'b0, 1'b0, "trap_recover");
`else
        issue(32'h00002083, 1'b0, 1'b0, "nop_load");
        check_eq("nop_illegal", 32'(bus_if.illegal), 32'd0);
        issue(enc_r(7'h00, 5'd0, 5'd10, 3'b000, 5'd12), 1'b0, 1'b0, "post_nop");
        check_eq("nop_kept_x10", cap_wb_data, 32'h000007FF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
